// File: rtl/fmul_sched_pkg.sv
// fmul_sched_pkg: shared widths, tag type and helpers for the FP32 multiply scheduler.
// Rev 1.0
`default_nettype none

package fmul_sched_pkg;

  localparam int FP32_W          = 32;
  localparam int MUL_LATENCY_DEF = 7;
  localparam int MAX_REQ         = 8;
  localparam int ID_W            = 3;

  // Ceiling log2; clog2(1) = 0.
  function automatic int clog2(input int value);
    int res;
    res = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) res = i + 1;
    end
    return res;
  endfunction

  typedef struct packed {
    logic            vld;
    logic [ID_W-1:0] id;
  } tag_t;

endpackage

`default_nettype wire

// File: rtl/fmul_rr_scheduler_arbiter.sv
// rr_arbiter: round-robin grant from an eligibility vector, pointer advances past each grant.
// Rev 1.0
`default_nettype none

module rr_arbiter
  import fmul_sched_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic               clkn,
  input  logic               rstn,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_id
);

  logic [ID_W-1:0] ptr;
  logic            found;
  int              idx;

  always_comb begin
    grant    = '0;
    grant_id = '0;
    found    = 1'b0;
    idx      = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant_id   = ID_W'(idx);
        grant[idx] = 1'b1;
      end
    end
  end

  always_ff @(negedge clkn or negedge rstn) begin
    if (!rstn) begin
      ptr <= '0;
    end else if (found) begin
      ptr <= (int'(grant_id) == NUM_REQ - 1) ? '0 : grant_id + ID_W'(1);
    end
  end

endmodule

`default_nettype wire

// File: rtl/fmul_rr_scheduler.sv
// fmul_rr_scheduler: round-robin sharing of one fixed-latency FP32 multiplier, results routed back by tag.
// Rev 1.0
`default_nettype none

module fmul_rr_scheduler
  import fmul_sched_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int MUL_LATENCY = MUL_LATENCY_DEF,
  parameter int MAX_OUT     = 4
) (
  input  logic                      clkn_i,
  input  logic                      rstn_i,
  input  logic [NUM_REQ-1:0]        req_valid_i,
  output logic [NUM_REQ-1:0]        req_ready_o,
  input  logic [NUM_REQ*FP32_W-1:0] req_a_i,
  input  logic [NUM_REQ*FP32_W-1:0] req_b_i,
  output logic [NUM_REQ-1:0]        resp_valid_o,
  output logic [FP32_W-1:0]         resp_data_o,
  output logic [FP32_W-1:0]         mul_a_o,
  output logic [FP32_W-1:0]         mul_b_o,
  input  logic [FP32_W-1:0]         mul_result_i,
  output logic                      busy_o
);

  localparam int CNT_W = clog2(MAX_OUT + 1);

  logic [CNT_W-1:0]   out_cnt [NUM_REQ];
  logic [NUM_REQ-1:0] eligible;
  logic [NUM_REQ-1:0] grant;
  logic [ID_W-1:0]    grant_id;
  logic               accept;
  logic [FP32_W-1:0]  sel_a;
  logic [FP32_W-1:0]  sel_b;
  logic [NUM_REQ-1:0] retire;

  // Entry 0 pairs with the operand registers; entry MUL_LATENCY lines up with mul_result_i.
  tag_t tag_line [MUL_LATENCY+1];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_elig
    assign eligible[g] = req_valid_i[g] && (out_cnt[g] < CNT_W'(MAX_OUT));
  end

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .clkn     (clkn_i),
    .rstn     (rstn_i),
    .req      (eligible),
    .grant    (grant),
    .grant_id (grant_id)
  );

  assign req_ready_o = grant;
  assign accept      = |grant;
  assign sel_a       = req_a_i[int'(grant_id)*FP32_W +: FP32_W];
  assign sel_b       = req_b_i[int'(grant_id)*FP32_W +: FP32_W];

  always_comb begin
    retire = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      retire[k] = tag_line[MUL_LATENCY].vld && (tag_line[MUL_LATENCY].id == ID_W'(k));
    end
  end

  always_ff @(negedge clkn_i or negedge rstn_i) begin
    if (!rstn_i) begin
      mul_a_o <= '0;
      mul_b_o <= '0;
      for (int k = 0; k <= MUL_LATENCY; k++) tag_line[k] <= '0;
    end else begin
      mul_a_o     <= accept ? sel_a : '0;
      mul_b_o     <= accept ? sel_b : '0;
      tag_line[0] <= '{vld: accept, id: grant_id};
      for (int k = 1; k <= MUL_LATENCY; k++) tag_line[k] <= tag_line[k-1];
    end
  end

  always_ff @(negedge clkn_i or negedge rstn_i) begin
    if (!rstn_i) begin
      resp_valid_o <= '0;
      resp_data_o  <= '0;
    end else begin
      resp_valid_o <= retire;
      if (tag_line[MUL_LATENCY].vld) resp_data_o <= mul_result_i;
    end
  end

  // A retire and an accept for the same requester on one edge cancel out.
  always_ff @(negedge clkn_i or negedge rstn_i) begin
    if (!rstn_i) begin
      for (int k = 0; k < NUM_REQ; k++) out_cnt[k] <= '0;
    end else begin
      for (int k = 0; k < NUM_REQ; k++) begin
        if (grant[k] && !retire[k]) out_cnt[k] <= out_cnt[k] + CNT_W'(1);
        else if (!grant[k] && retire[k]) out_cnt[k] <= out_cnt[k] - CNT_W'(1);
      end
    end
  end

  always_comb begin
    busy_o = |resp_valid_o;
    for (int k = 0; k <= MUL_LATENCY; k++) busy_o = busy_o | tag_line[k].vld;
  end

endmodule

`default_nettype wire
